// File: rtl/tile_scheduler.sv
// Layer tile generator: latches a layer descriptor and issues clipped tile
// descriptors (cols fastest, then rows, then output-channel groups) over valid/ready.
module tile_scheduler #(
    parameter int unsigned DIM_W     = 16,
    parameter int unsigned TILE_ROWS = 4,
    parameter int unsigned TILE_COLS = 4,
    parameter int unsigned POF       = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIM_W-1:0] cfg_rows_i,
    input  logic [DIM_W-1:0] cfg_cols_i,
    input  logic [DIM_W-1:0] cfg_in_ch_i,
    input  logic [DIM_W-1:0] cfg_out_ch_i,
    input  logic             cfg_is_dfconv_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o,
    output logic             tile_valid_o,
    input  logic             tile_ready_i,
    output logic             tile_is_dfconv_o,
    output logic [DIM_W-1:0] tile_row0_o,
    output logic [DIM_W-1:0] tile_col0_o,
    output logic [DIM_W-1:0] tile_och0_o,
    output logic [DIM_W-1:0] tile_rows_o,
    output logic [DIM_W-1:0] tile_cols_o,
    output logic [DIM_W-1:0] tile_och_o,
    output logic [DIM_W-1:0] tile_in_ch_o,
    output logic             tile_last_o
);

    localparam logic [DIM_W-1:0] TR = DIM_W'(TILE_ROWS);
    localparam logic [DIM_W-1:0] TC = DIM_W'(TILE_COLS);
    localparam logic [DIM_W-1:0] TP = DIM_W'(POF);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FIN} state_e;

    state_e           state_q;
    logic [DIM_W-1:0] rows_q, cols_q, out_ch_q, in_ch_q;
    logic             dfconv_q;
    logic [DIM_W-1:0] row0_q, col0_q, och0_q;
    logic [DIM_W-1:0] ext_rows_q, ext_cols_q, ext_och_q;
    logic             last_q, busy_q, valid_q, done_q, cfg_err_q;

    logic [DIM_W-1:0] rows_d, cols_d, out_ch_d;
    logic [DIM_W-1:0] row0_d, col0_d, och0_d;
    logic [DIM_W-1:0] ext_rows_d, ext_cols_d, ext_och_d;
    logic             last_d;
    logic             start_ok_c;
    logic             col_end_c, row_end_c;

    // Extent is taken from the remaining distance so it cannot overflow.
    function automatic logic [DIM_W-1:0] clip(input logic [DIM_W-1:0] dim,
                                              input logic [DIM_W-1:0] pos,
                                              input logic [DIM_W-1:0] tile);
        logic [DIM_W-1:0] rem;
        rem = dim - pos;
        return (rem < tile) ? rem : tile;
    endfunction

    // One extra bit keeps pos + tile from wrapping near the top of the range.
    function automatic logic at_end(input logic [DIM_W-1:0] dim,
                                    input logic [DIM_W-1:0] pos,
                                    input logic [DIM_W-1:0] tile);
        return ({1'b0, pos} + {1'b0, tile}) >= {1'b0, dim};
    endfunction

    assign start_ok_c = (cfg_rows_i != '0) && (cfg_cols_i != '0) &&
                        (cfg_in_ch_i != '0) && (cfg_out_ch_i != '0);

    // Next cursor position: a fresh layer from IDLE, otherwise one step along the walk.
    always_comb begin
        rows_d    = rows_q;
        cols_d    = cols_q;
        out_ch_d  = out_ch_q;
        row0_d    = row0_q;
        col0_d    = col0_q;
        och0_d    = och0_q;
        col_end_c = at_end(cols_q, col0_q, TC);
        row_end_c = at_end(rows_q, row0_q, TR);
        if (state_q == S_IDLE) begin
            rows_d   = cfg_rows_i;
            cols_d   = cfg_cols_i;
            out_ch_d = cfg_out_ch_i;
            row0_d   = '0;
            col0_d   = '0;
            och0_d   = '0;
        end else if (!col_end_c) begin
            col0_d = col0_q + TC;
        end else begin
            col0_d = '0;
            if (!row_end_c) begin
                row0_d = row0_q + TR;
            end else begin
                row0_d = '0;
                och0_d = och0_q + TP;
            end
        end
        ext_rows_d = clip(rows_d, row0_d, TR);
        ext_cols_d = clip(cols_d, col0_d, TC);
        ext_och_d  = clip(out_ch_d, och0_d, TP);
        last_d     = at_end(cols_d, col0_d, TC) && at_end(rows_d, row0_d, TR) &&
                     at_end(out_ch_d, och0_d, TP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            out_ch_q   <= '0;
            in_ch_q    <= '0;
            dfconv_q   <= 1'b0;
            row0_q     <= '0;
            col0_q     <= '0;
            och0_q     <= '0;
            ext_rows_q <= '0;
            ext_cols_q <= '0;
            ext_och_q  <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && start_ok_c) begin
                        rows_q     <= rows_d;
                        cols_q     <= cols_d;
                        out_ch_q   <= out_ch_d;
                        in_ch_q    <= cfg_in_ch_i;
                        dfconv_q   <= cfg_is_dfconv_i;
                        row0_q     <= row0_d;
                        col0_q     <= col0_d;
                        och0_q     <= och0_d;
                        ext_rows_q <= ext_rows_d;
                        ext_cols_q <= ext_cols_d;
                        ext_och_q  <= ext_och_d;
                        last_q     <= last_d;
                        busy_q     <= 1'b1;
                        valid_q    <= 1'b1;
                        state_q    <= S_ISSUE;
                    end else if (start_i) begin
                        done_q    <= 1'b1;
                        cfg_err_q <= 1'b1;
                        state_q   <= S_FIN;
                    end
                end
                S_ISSUE: begin
                    if (tile_ready_i && last_q) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else if (tile_ready_i) begin
                        row0_q     <= row0_d;
                        col0_q     <= col0_d;
                        och0_q     <= och0_d;
                        ext_rows_q <= ext_rows_d;
                        ext_cols_q <= ext_cols_d;
                        ext_och_q  <= ext_och_d;
                        last_q     <= last_d;
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign cfg_err_o        = cfg_err_q;
    assign tile_valid_o     = valid_q;
    assign tile_is_dfconv_o = dfconv_q;
    assign tile_row0_o      = row0_q;
    assign tile_col0_o      = col0_q;
    assign tile_och0_o      = och0_q;
    assign tile_rows_o      = ext_rows_q;
    assign tile_cols_o      = ext_cols_q;
    assign tile_och_o       = ext_och_q;
    assign tile_in_ch_o     = in_ch_q;
    assign tile_last_o      = last_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: tile tables, backpressure, config error,
// ignored start, mid-run reset and the 16-bit row boundary.
module tb_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_i, start_i, cfg_is_dfconv_i, tile_ready_i;
    logic [15:0] cfg_rows_i, cfg_cols_i, cfg_in_ch_i, cfg_out_ch_i;
    logic        busy_o, done_o, cfg_err_o, tile_valid_o, tile_is_dfconv_o, tile_last_o;
    logic [15:0] tile_row0_o, tile_col0_o, tile_och0_o;
    logic [15:0] tile_rows_o, tile_cols_o, tile_och_o, tile_in_ch_o;

    always #5 clk = ~clk;

    tile_scheduler dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .cfg_rows_i(cfg_rows_i), .cfg_cols_i(cfg_cols_i),
        .cfg_in_ch_i(cfg_in_ch_i), .cfg_out_ch_i(cfg_out_ch_i),
        .cfg_is_dfconv_i(cfg_is_dfconv_i),
        .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o),
        .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
        .tile_is_dfconv_o(tile_is_dfconv_o),
        .tile_row0_o(tile_row0_o), .tile_col0_o(tile_col0_o), .tile_och0_o(tile_och0_o),
        .tile_rows_o(tile_rows_o), .tile_cols_o(tile_cols_o), .tile_och_o(tile_och_o),
        .tile_in_ch_o(tile_in_ch_o), .tile_last_o(tile_last_o)
    );

    typedef struct {
        logic [15:0] row0, col0, och0, rows, cols, och;
        logic        last;
    } tile_t;

    tile_t case1 [8];
    tile_t case2 [8];
    tile_t exp_q [$];
    int    nvec  = 0;
    int    nfail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] dut_pack();
        return 128'({tile_row0_o, tile_col0_o, tile_och0_o, tile_rows_o, tile_cols_o,
                     tile_och_o, tile_in_ch_o, tile_is_dfconv_o, tile_last_o});
    endfunction

    function automatic logic [127:0] exp_pack(input tile_t t, input logic [15:0] ic, input logic df);
        return 128'({t.row0, t.col0, t.och0, t.rows, t.cols, t.och, ic, df, t.last});
    endfunction

    function automatic tile_t mk(input int r0, input int c0, input int o0,
                                 input int r, input int c, input int o, input bit l);
        tile_t t;
        t.row0 = 16'(r0); t.col0 = 16'(c0); t.och0 = 16'(o0);
        t.rows = 16'(r);  t.cols = 16'(c);  t.och  = 16'(o);
        t.last = l;
        return t;
    endfunction

    // Starts a layer and consumes exp_q, checking every handshake, stall stability and done.
    task automatic run_layer(input logic [15:0] r, input logic [15:0] c, input logic [15:0] ic,
                             input logic [15:0] oc, input logic df, input bit rnd, input bit poke);
        int           idx, cyc;
        bit           stalled, rdy;
        logic [127:0] cur, held;
        cfg_rows_i = r; cfg_cols_i = c; cfg_in_ch_i = ic; cfg_out_ch_i = oc;
        cfg_is_dfconv_i = df;
        start_i = 1'b1; tile_ready_i = 1'b0;
        step();
        start_i = 1'b0;
        cfg_rows_i = 16'h0bad; cfg_cols_i = 16'h0bad; cfg_out_ch_i = 16'h0bad;
        cfg_in_ch_i = 16'h0bad; cfg_is_dfconv_i = ~df;
        chk("busy_on", 128'(busy_o), 128'(1));
        chk("valid_on", 128'(tile_valid_o), 128'(1));
        idx = 0; cyc = 0; stalled = 0; held = '0;
        while (idx < exp_q.size() && cyc < 40000) begin
            cur = dut_pack();
            if (stalled) chk("stall_stable", cur, held);
            if (!tile_valid_o) begin
                nfail++;
                $display("FAIL valid_drop: got 0 expected 1 at tile %0d", idx);
                break;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tile_ready_i = rdy;
            start_i = poke && (cyc == 2);
            if (rdy) begin
                chk($sformatf("tile%0d", idx), cur, exp_pack(exp_q[idx], ic, df));
                idx++;
                stalled = 0;
            end else begin
                held = cur;
                stalled = 1;
            end
            step();
            cyc++;
        end
        tile_ready_i = 1'b0; start_i = 1'b0;
        if (idx < exp_q.size()) begin
            nfail++;
            $display("FAIL handshakes: got %0d expected %0d", idx, exp_q.size());
        end
        chk("done_pulse", 128'({done_o, cfg_err_o, busy_o, tile_valid_o}), 128'(4'b1000));
        step();
        chk("done_clear", 128'({done_o, cfg_err_o, busy_o, tile_valid_o}), 128'(4'b0000));
    endtask

    initial begin
        case1[0] = mk(0, 0, 0, 4, 4, 2, 0);   case1[1] = mk(0, 0, 2, 4, 4, 2, 0);
        case1[2] = mk(0, 0, 4, 4, 4, 2, 0);   case1[3] = mk(0, 0, 6, 4, 4, 2, 0);
        case1[4] = mk(0, 0, 8, 4, 4, 2, 0);   case1[5] = mk(0, 0, 10, 4, 4, 2, 0);
        case1[6] = mk(0, 0, 12, 4, 4, 2, 0);  case1[7] = mk(0, 0, 14, 4, 4, 2, 1);
        case2[0] = mk(0, 0, 0, 4, 4, 2, 0);   case2[1] = mk(0, 4, 0, 4, 1, 2, 0);
        case2[2] = mk(4, 0, 0, 2, 4, 2, 0);   case2[3] = mk(4, 4, 0, 2, 1, 2, 0);
        case2[4] = mk(0, 0, 2, 4, 4, 1, 0);   case2[5] = mk(0, 4, 2, 4, 1, 1, 0);
        case2[6] = mk(4, 0, 2, 2, 4, 1, 0);   case2[7] = mk(4, 4, 2, 2, 1, 1, 1);

        rst_i = 1'b1; start_i = 1'b0; tile_ready_i = 1'b0; cfg_is_dfconv_i = 1'b0;
        cfg_rows_i = '0; cfg_cols_i = '0; cfg_in_ch_i = '0; cfg_out_ch_i = '0;
        step(); step();
        chk("rst_ctrl", 128'({busy_o, done_o, cfg_err_o, tile_valid_o}), 128'(0));
        chk("rst_fields", dut_pack(), 128'(0));
        rst_i = 1'b0;
        step();

        // Basic layer with ready held high.
        exp_q.delete();
        foreach (case1[i]) exp_q.push_back(case1[i]);
        run_layer(16'd4, 16'd4, 16'd16, 16'd16, 1'b0, 1'b0, 1'b0);

        // Edge clipping in DFConv mode.
        exp_q.delete();
        foreach (case2[i]) exp_q.push_back(case2[i]);
        run_layer(16'd6, 16'd5, 16'd7, 16'd3, 1'b1, 1'b0, 1'b0);

        // Backpressure with random ready.
        exp_q.delete();
        foreach (case1[i]) exp_q.push_back(case1[i]);
        run_layer(16'd4, 16'd4, 16'd16, 16'd16, 1'b0, 1'b1, 1'b0);

        // Config error: zero cols.
        cfg_rows_i = 16'd4; cfg_cols_i = 16'd0; cfg_in_ch_i = 16'd16; cfg_out_ch_i = 16'd16;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("err_pulse", 128'({done_o, cfg_err_o, busy_o, tile_valid_o}), 128'(4'b1100));
        step();
        chk("err_clear", 128'({done_o, cfg_err_o, busy_o, tile_valid_o}), 128'(4'b0000));
        // Restart two cycles after the erroneous start, with a stray start mid-run.
        run_layer(16'd4, 16'd4, 16'd16, 16'd16, 1'b0, 1'b0, 1'b1);

        // Mid-run reset after the 3rd handshake.
        cfg_rows_i = 16'd4; cfg_cols_i = 16'd4; cfg_in_ch_i = 16'd16; cfg_out_ch_i = 16'd16;
        cfg_is_dfconv_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0; tile_ready_i = 1'b1;
        step(); step(); step();
        chk("pre_rst_tile", dut_pack(), exp_pack(mk(0, 0, 6, 4, 4, 2, 0), 16'd16, 1'b1));
        rst_i = 1'b1; tile_ready_i = 1'b0;
        step();
        rst_i = 1'b0;
        chk("midrst_ctrl", 128'({busy_o, done_o, cfg_err_o, tile_valid_o}), 128'(0));
        chk("midrst_fields", dut_pack(), 128'(0));
        exp_q.delete();
        foreach (case1[i]) exp_q.push_back(case1[i]);
        run_layer(16'd4, 16'd4, 16'd16, 16'd16, 1'b0, 1'b0, 1'b0);

        // Width boundary: 65535 rows in one column, 16384 tiles, last is 3 rows at 65532.
        exp_q.delete();
        for (int i = 0; i < 16384; i++)
            exp_q.push_back(mk(4 * i, 0, 0, (i == 16383) ? 3 : 4, 1, 1, i == 16383));
        chk("wide_last_row0", 128'(exp_q[16383].row0), 128'(16'd65532));
        run_layer(16'd65535, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
